// File: rtl/ternary_pkg.sv
// ----------------------------------------------------------------------------
// ternary_pkg
// Shared balanced-ternary types and helpers for the serial subtractor.
//   trit_t        : 2-bit trit encoding (T_NEG=2'b10, T_ZERO=2'b00, T_POS=2'b01)
//   trit_neg      : negates a trit
//   trit_val      : trit -> small signed integer (-1/0/+1)
//   val_to_trit   : small signed integer sign -> trit
//   tsub_state_t  : subtractor FSM state encoding
// The code 2'b11 is unused and is read as zero wherever it is decoded.
// ----------------------------------------------------------------------------
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t T_ZERO = 2'b00;
  localparam trit_t T_POS  = 2'b01;
  localparam trit_t T_NEG  = 2'b10;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_RUN  = 2'd1,
    TS_DONE = 2'd2
  } tsub_state_t;

  // Swap the signed codes; zero (and the unused code) maps to zero.
  function automatic trit_t trit_neg(input trit_t t);
    case (t)
      T_POS:   return T_NEG;
      T_NEG:   return T_POS;
      default: return T_ZERO;
    endcase
  endfunction

  // Numeric value of one trit as a 3-bit signed quantity.
  function automatic logic signed [2:0] trit_val(input trit_t t);
    case (t)
      T_POS:   return 3'sd1;
      T_NEG:   return -3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  // Sign of a small signed value expressed as a trit.
  function automatic trit_t val_to_trit(input logic signed [2:0] v);
    if (v > 3'sd0) begin
      return T_POS;
    end else if (v < 3'sd0) begin
      return T_NEG;
    end else begin
      return T_ZERO;
    end
  endfunction

endpackage : ternary_pkg

// File: rtl/ternary_serial_subtractor_btfa.sv
// ----------------------------------------------------------------------------
// btfa
// Balanced-ternary full-adder cell: i_a + i_b + i_cin = o_sum_c + 3*o_cout_c.
// Purely combinational.
//   i_a, i_b   : addend trits
//   i_cin      : carry-in trit
//   o_sum_c    : sum trit
//   o_cout_c   : carry-out trit
// ----------------------------------------------------------------------------
module btfa
  import ternary_pkg::*;
(
  input  trit_t i_a,
  input  trit_t i_b,
  input  trit_t i_cin,
  output trit_t o_sum_c,
  output trit_t o_cout_c
);

  logic signed [2:0] w_total;
  logic signed [2:0] w_rem;

  // Raw sum lies in [-3, 3], which fits a 3-bit signed value.
  assign w_total = trit_val(i_a) + trit_val(i_b) + trit_val(i_cin);

  // Fold totals of magnitude 2 or 3 into a carry, leaving a remainder in [-1, 1].
  always_comb begin
    w_rem    = w_total;
    o_cout_c = T_ZERO;
    if (w_total > 3'sd1) begin
      o_cout_c = T_POS;
      w_rem    = w_total - 3'sd3;
    end else if (w_total < -3'sd1) begin
      o_cout_c = T_NEG;
      w_rem    = w_total + 3'sd3;
    end
  end

  assign o_sum_c = val_to_trit(w_rem);

endmodule : btfa

// File: rtl/ternary_serial_subtractor.sv
// ----------------------------------------------------------------------------
// ternary_serial_subtractor
// Digit-serial balanced-ternary subtractor: computes a - b + cin one trit per
// cycle, LSB first, through a single btfa cell with the subtrahend negated.
// Optional feature macro: TERNARY_SUB_CMP_EN adds the cmp port (sign of the
// full result, valid while out_valid is high).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : minuend, subtrahend, carry-in trit
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   diff, cout          : low WIDTH trits of the result and the 3^WIDTH carry
//   cmp                 : result sign (TERNARY_SUB_CMP_EN only)
// ----------------------------------------------------------------------------
module ternary_serial_subtractor
  import ternary_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  trit_t [WIDTH-1:0]      a,
  input  trit_t [WIDTH-1:0]      b,
  input  trit_t                  cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output trit_t [WIDTH-1:0]      diff,
  output trit_t                  cout
`ifdef TERNARY_SUB_CMP_EN
  ,
  output trit_t                  cmp
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  tsub_state_t          r_state;
  tsub_state_t          w_state_next;
  trit_t [WIDTH-1:0]    r_a_sh;
  trit_t [WIDTH-1:0]    r_b_sh;
  trit_t [WIDTH-1:0]    r_diff_sh;
  trit_t [WIDTH-1:0]    w_diff_next;
  trit_t                r_carry;
  logic  [CNT_W-1:0]    r_cnt;

  trit_t                w_b_neg;
  trit_t                w_sum;
  trit_t                w_cout;
  logic                 w_accept;
  logic                 w_run;
  logic                 w_last;

  assign w_accept = (r_state == TS_IDLE) && in_valid;
  assign w_run    = (r_state == TS_RUN);
  assign w_last   = w_run && (r_cnt == CNT_W'(WIDTH - 1));

  // Subtraction is addition of the negated subtrahend trit.
  assign w_b_neg = trit_neg(r_b_sh[0]);

  btfa u_btfa (
    .i_a      (r_a_sh[0]),
    .i_b      (w_b_neg),
    .i_cin    (r_carry),
    .o_sum_c  (w_sum),
    .o_cout_c (w_cout)
  );

  // New sum trit enters at the top; after WIDTH steps trit 0 sits at the bottom.
  always_comb begin
    w_diff_next        = r_diff_sh >> 2;
    w_diff_next[WIDTH-1] = w_sum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TS_IDLE: if (in_valid)  w_state_next = TS_RUN;
      TS_RUN:  if (w_last)    w_state_next = TS_DONE;
      TS_DONE: if (out_ready) w_state_next = TS_IDLE;
      default:                w_state_next = TS_IDLE;
    endcase
  end

  // Operand, result and carry datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_diff_sh <= '0;
      r_carry   <= T_ZERO;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a_sh    <= r_a_sh >> 2;
      r_b_sh    <= r_b_sh >> 2;
      r_diff_sh <= w_diff_next;
      r_carry   <= w_cout;
      r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

`ifdef TERNARY_SUB_CMP_EN
  trit_t r_sign;

  // The last nonzero trit seen is the most significant one, hence the sign;
  // a nonzero final carry outranks every diff trit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= T_ZERO;
    end else if (w_accept) begin
      r_sign <= T_ZERO;
    end else if (w_run) begin
      if (w_last && (w_cout != T_ZERO)) begin
        r_sign <= w_cout;
      end else if (w_sum != T_ZERO) begin
        r_sign <= w_sum;
      end
    end
  end

  assign cmp = r_sign;
`endif

  // Handshake flags decode registered state only.
  assign in_ready  = (r_state == TS_IDLE);
  assign out_valid = (r_state == TS_DONE);
  assign diff      = r_diff_sh;
  assign cout      = r_carry;

endmodule : ternary_serial_subtractor

// File: tb/tb_ternary_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_ternary_serial_subtractor
// Self-checking bench for ternary_serial_subtractor at WIDTH=4. Expected
// results come from integer arithmetic on the operand values.
// ----------------------------------------------------------------------------
module tb_ternary_serial_subtractor;
  import ternary_pkg::*;

  localparam int W    = 4;
  localparam int MODV = 81;   // 3^W
  localparam int MAXV = 40;   // (3^W - 1) / 2

  typedef trit_t [W-1:0] tvec_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  logic  in_ready;
  tvec_t a;
  tvec_t b;
  trit_t cin;
  logic  out_valid;
  logic  out_ready;
  tvec_t diff;
  trit_t cout;
`ifdef TERNARY_SUB_CMP_EN
  trit_t cmp;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  ternary_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .cout      (cout)
`ifdef TERNARY_SUB_CMP_EN
    ,
    .cmp       (cmp)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int dtrit(input trit_t t);
    if (t == T_POS) return 1;
    if (t == T_NEG) return -1;
    return 0;
  endfunction

  function automatic trit_t etrit(input int v);
    if (v > 0) return T_POS;
    if (v < 0) return T_NEG;
    return T_ZERO;
  endfunction

  function automatic int dec(input tvec_t v);
    int s = 0;
    int p = 1;
    for (int i = 0; i < W; i++) begin
      s += dtrit(v[i]) * p;
      p *= 3;
    end
    return s;
  endfunction

  // Balanced-ternary digits by repeated division with remainder in {-1,0,1}.
  function automatic tvec_t enc(input int v);
    tvec_t r = '0;
    int x = v;
    int m;
    for (int i = 0; i < W; i++) begin
      m = ((x % 3) + 3) % 3;
      if (m == 1) begin
        r[i] = T_POS; x = (x - 1) / 3;
      end else if (m == 2) begin
        r[i] = T_NEG; x = (x + 1) / 3;
      end else begin
        x = x / 3;
      end
    end
    return r;
  endfunction

  // Reference: split a-b+cin into a carry of weight 3^W and a W-trit remainder.
  function automatic void model(input int av, input int bv, input int cv,
                                output int ed, output int ec, output int es);
    int r = av - bv + cv;
    ec = (r > MAXV) ? 1 : ((r < -MAXV) ? -1 : 0);
    ed = r - ec * MODV;
    es = (r > 0) ? 1 : ((r < 0) ? -1 : 0);
  endfunction

  // One full transaction; starts and ends on a falling edge with in_ready expected high.
  task automatic do_op(input int av, input int bv, input int cv, input int stall);
    int ed, ec, es, lat, gd;
    model(av, bv, cv, ed, ec, es);
    out_ready = (stall == 0);
    gd = 0;
    while (!in_ready && gd < 50) begin
      @(negedge clk); gd++;
    end
    chk("rdy_wait", int'(in_ready), 1);
    a = enc(av); b = enc(bv); cin = etrit(cv); in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        a = enc(-av); b = enc(-bv);
      end
      if (!out_valid) chk("busy_rdy", int'(in_ready), 0);
    end while (!out_valid && lat < 4 * W + 8);
    chk("latency", lat, W + 1);
    chk("diff", dec(diff), ed);
    chk("cout", dtrit(cout), ec);
`ifdef TERNARY_SUB_CMP_EN
    chk("cmp", dtrit(cmp), es);
`endif
    chk("done_rdy", int'(in_ready), 0);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      a = enc(int'($urandom_range(0, 80)) - MAXV);
      @(negedge clk);
      chk("hold_vld", int'(out_valid), 1);
      chk("hold_rdy", int'(in_ready), 0);
      chk("hold_diff", dec(diff), ed);
      chk("hold_cout", dtrit(cout), ec);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_rdy", int'(in_ready), 1);
    chk("rel_vld", int'(out_valid), 0);
  endtask

  initial begin
    int ed1, ec1, es1, ed2, ec2, es2, nres, t1, t2, cyc;
    logic drop;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = T_ZERO;
    repeat (2) @(negedge clk);
    chk("rst_rdy", int'(in_ready), 1);
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_diff", dec(diff), 0);
    chk("rst_cout", dtrit(cout), 0);
`ifdef TERNARY_SUB_CMP_EN
    chk("rst_cmp", dtrit(cmp), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op(5, 3, 0, 0);
    do_op(40, -40, 0, 0);
    do_op(-40, 40, -1, 0);
    do_op(3, 7, 0, 3);

    // Reset in the middle of RUN discards the operation.
    a = enc(30); b = enc(-20); cin = T_POS; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_vld", int'(out_valid), 0);
    chk("abort_rdy", int'(in_ready), 1);
    chk("abort_diff", dec(diff), 0);
    chk("abort_cout", dtrit(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1, 1, 0, 0);

    // Back-to-back: second pair waits for IDLE while in_valid stays high.
    model(17, -9, 1, ed1, ec1, es1);
    model(-25, 31, -1, ed2, ec2, es2);
    out_ready = 1'b1;
    a = enc(17); b = enc(-9); cin = T_POS; in_valid = 1'b1;
    @(negedge clk);
    a = enc(-25); b = enc(31); cin = T_NEG;
    nres = 0; t1 = 0; t2 = 0; drop = 1'b0;
    for (cyc = 1; cyc < 60 && nres < 2; cyc++) begin
      @(negedge clk);
      if (drop) begin
        in_valid = 1'b0; drop = 1'b0;
      end
      if (out_valid) begin
        chk("b2b_rdy", int'(in_ready), 0);
        if (nres == 0) begin
          chk("b2b_diff1", dec(diff), ed1);
          chk("b2b_cout1", dtrit(cout), ec1);
          t1 = cyc;
        end else begin
          chk("b2b_diff2", dec(diff), ed2);
          chk("b2b_cout2", dtrit(cout), ec2);
          t2 = cyc;
        end
        nres++;
      end
      if (in_ready && in_valid) begin
        chk("b2b_accept_after1", nres, 1);
        drop = 1'b1;
      end
    end
    chk("b2b_count", nres, 2);
    chk("b2b_spacing", t2 - t1, W + 2);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Randomized operations.
    for (int k = 0; k < 12; k++) begin
      do_op(int'($urandom_range(0, 80)) - MAXV,
            int'($urandom_range(0, 80)) - MAXV,
            int'($urandom_range(0, 2)) - 1,
            int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_ternary_serial_subtractor
